angle_step_driver: RTL and testbench

Downstream consumer of the angle solver. Accepts a pair of signed 13-bit joint angle targets (th1, th2) with a valid pulse, computes signed deltas against its tracked joint positions, and drives two stepper channels (step/dir) at a fixed step rate until both joints reach target. Pulses `done` and returns to idle to accept the next solution. Tracked positions are exported for monitoring. One angle LSB equals one motor step.

---
 rtl/angle_step_driver.sv | 137 +++++++++++++
 tb/tb_angle_step_driver.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/angle_step_driver.sv
// Two-channel step/dir driver: takes a joint angle target pair, steps both joints
// toward it at a fixed rate, then pulses done and returns to idle.
module angle_step_driver #(
  parameter int STEP_DIV = 5000,
  parameter int PULSE_W  = 50,
  parameter int SETTLE   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [12:0] th1_in,
  input  logic signed [12:0] th2_in,
  input  logic               angles_valid,
  input  logic               home,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic               step1,
  output logic               step2,
  output logic               dir1,
  output logic               dir2,
  output logic signed [12:0] pos1,
  output logic signed [12:0] pos2
);

  localparam int DATA_W = 13;
  localparam int CNT_W  = $clog2(STEP_DIV);
  localparam int SET_W  = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {IDLE, LOAD, DIR_SETUP, RUN, DONE} state_t;

  state_t                    state, state_nxt;
  logic signed [DATA_W-1:0]  tgt1, tgt2;
  logic signed [DATA_W:0]    delta1, delta2;
  logic        [DATA_W-1:0]  rem1, rem2;
  logic        [CNT_W-1:0]   cnt;
  logic        [SET_W-1:0]   scnt;
  logic                      act1, act2;
  logic                      settle_end, period_end, rem_zero, start_period;

  // Magnitude of a 14-bit delta; the delta range is +/-8191 so it always fits 13 bits.
  function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W:0] d);
    mag = d[DATA_W] ? DATA_W'(-d) : DATA_W'(d);
  endfunction

  function automatic logic signed [DATA_W-1:0] step_pos(input logic signed [DATA_W-1:0] p,
                                                        input logic neg);
    step_pos = neg ? p - DATA_W'(1) : p + DATA_W'(1);
  endfunction

  assign delta1 = $signed({tgt1[DATA_W-1], tgt1}) - $signed({pos1[DATA_W-1], pos1});
  assign delta2 = $signed({tgt2[DATA_W-1], tgt2}) - $signed({pos2[DATA_W-1], pos2});

  assign settle_end   = (state == DIR_SETUP) && (scnt == SET_W'(SETTLE - 1));
  assign period_end   = (state == RUN) && (cnt == CNT_W'(STEP_DIV - 1));
  assign rem_zero     = (rem1 == '0) && (rem2 == '0);
  // Positions advance on the edge that opens a step period, so pos changes with the rising step.
  assign start_period = (settle_end || period_end) && !rem_zero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (angles_valid) state_nxt = LOAD;
      LOAD:      state_nxt = DIR_SETUP;
      DIR_SETUP: if (settle_end) state_nxt = rem_zero ? DONE : RUN;
      RUN:       if (period_end && rem_zero) state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tgt1 <= '0;
      tgt2 <= '0;
      pos1 <= '0;
      pos2 <= '0;
      rem1 <= '0;
      rem2 <= '0;
      dir1 <= 1'b0;
      dir2 <= 1'b0;
      cnt  <= '0;
      scnt <= '0;
      act1 <= 1'b0;
      act2 <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (angles_valid) begin
            tgt1 <= th1_in;
            tgt2 <= th2_in;
          end else if (home) begin
            pos1 <= '0;
            pos2 <= '0;
          end
        end
        LOAD: begin
          dir1 <= delta1[DATA_W];
          dir2 <= delta2[DATA_W];
          rem1 <= mag(delta1);
          rem2 <= mag(delta2);
          scnt <= '0;
          cnt  <= '0;
          act1 <= 1'b0;
          act2 <= 1'b0;
        end
        DIR_SETUP: scnt <= scnt + SET_W'(1);
        RUN:       cnt  <= period_end ? '0 : cnt + CNT_W'(1);
        default: ;
      endcase
      if (start_period) begin
        cnt  <= '0;
        act1 <= (rem1 != '0);
        act2 <= (rem2 != '0);
        if (rem1 != '0) begin
          pos1 <= step_pos(pos1, dir1);
          rem1 <= rem1 - DATA_W'(1);
        end
        if (rem2 != '0) begin
          pos2 <= step_pos(pos2, dir2);
          rem2 <= rem2 - DATA_W'(1);
        end
      end
    end
  end

  assign ready = (state == IDLE);
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign step1 = (state == RUN) && act1 && (cnt < CNT_W'(PULSE_W));
  assign step2 = (state == RUN) && act2 && (cnt < CNT_W'(PULSE_W));

endmodule

// File: tb/tb_angle_step_driver.sv
// Bench for angle_step_driver: table of moves plus random moves checked cycle by cycle
// against closed-form timing, and a fast-clocked instance for the full 13-bit span.
module tb_angle_step_driver;

  localparam int SD = 10;
  localparam int PW = 3;
  localparam int S  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic signed [12:0] th1 = '0, th2 = '0;
  logic angles_valid = 1'b0, home = 1'b0;
  logic ready, busy, done, step1, step2, dir1, dir2;
  logic signed [12:0] pos1, pos2;

  logic signed [12:0] sp_th1 = '0, sp_th2 = '0;
  logic sp_valid = 1'b0, sp_home = 1'b0;
  logic sp_ready, sp_busy, sp_done, sp_step1, sp_step2, sp_dir1, sp_dir2;
  logic signed [12:0] sp_pos1, sp_pos2;

  int checks = 0;
  int failures = 0;
  int m1 = 0, m2 = 0;

  always #5 clk = ~clk;

  angle_step_driver #(.STEP_DIV(SD), .PULSE_W(PW), .SETTLE(S)) u_dut (
    .clk(clk), .reset(reset), .th1_in(th1), .th2_in(th2), .angles_valid(angles_valid),
    .home(home), .ready(ready), .busy(busy), .done(done), .step1(step1), .step2(step2),
    .dir1(dir1), .dir2(dir2), .pos1(pos1), .pos2(pos2)
  );

  angle_step_driver #(.STEP_DIV(2), .PULSE_W(1), .SETTLE(S)) u_span (
    .clk(clk), .reset(reset), .th1_in(sp_th1), .th2_in(sp_th2), .angles_valid(sp_valid),
    .home(sp_home), .ready(sp_ready), .busy(sp_busy), .done(sp_done), .step1(sp_step1),
    .step2(sp_step2), .dir1(sp_dir1), .dir2(sp_dir2), .pos1(sp_pos1), .pos2(sp_pos2)
  );

  logic sp_s1_q = 1'b0, sp_s2_q = 1'b0;
  int sp_r1 = 0, sp_r2 = 0;
  always @(negedge clk) begin
    if (sp_step1 && !sp_s1_q) sp_r1 <= sp_r1 + 1;
    if (sp_step2 && !sp_s2_q) sp_r2 <= sp_r2 + 1;
    sp_s1_q <= sp_step1;
    sp_s2_q <= sp_step2;
  end

  typedef struct {
    int t1, t2, hmode, inj, rst, exp_done, exp_p1, exp_p2;
  } vec_t;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, " ready"}, int'(ready), 1);
    chk({nm, " busy/done"}, int'({busy, done}), 0);
    chk({nm, " steps"}, int'({step1, step2}), 0);
    chk({nm, " dirs"}, int'({dir1, dir2}), 0);
    chk({nm, " pos1"}, int'(pos1), 0);
    chk({nm, " pos2"}, int'(pos2), 0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) chk("wait for ready", int'(ready), 1);
  endtask

  // Applies one move and checks every cycle against the closed-form schedule.
  task automatic move(input vec_t v, input string nm);
    int d1, d2, a1, a2, mm, td, first_done, r, k, n1, n2;
    int bs1, bs2, bp, bd, bb, bdir;
    bit inrun, aborted;
    logic es1, es2;
    bs1 = 0; bs2 = 0; bp = 0; bd = 0; bb = 0; bdir = 0; aborted = 0; first_done = -1;
    wait_ready();
    if (v.hmode == 1) begin
      home = 1'b1;
      @(negedge clk);
      home = 1'b0;
      m1 = 0;
      m2 = 0;
      chk({nm, " home pos1"}, int'(pos1), 0);
      chk({nm, " home pos2"}, int'(pos2), 0);
    end
    home = (v.hmode == 2);
    th1 = v.t1[12:0];
    th2 = v.t2[12:0];
    angles_valid = 1'b1;
    d1 = v.t1 - m1;
    d2 = v.t2 - m2;
    a1 = (d1 < 0) ? -d1 : d1;
    a2 = (d2 < 0) ? -d2 : d2;
    mm = (a1 > a2) ? a1 : a2;
    td = S + 2 + mm * SD;
    for (int t = 1; t <= td; t++) begin
      @(negedge clk);
      angles_valid = (t == v.inj);
      home = 1'b0;
      if (t == v.inj) begin
        th1 = 13'sd77;
        th2 = -13'sd55;
      end
      r = t - S - 2;
      inrun = (r >= 0) && (t < td || mm == 0 ? (t < td) : 1'b0);
      inrun = (r >= 0) && (r < mm * SD);
      k = (r >= 0) ? r / SD : 0;
      es1 = inrun && (k < a1) && (r % SD < PW);
      es2 = inrun && (k < a2) && (r % SD < PW);
      n1 = (r < 0) ? 0 : ((k + 1 < a1) ? k + 1 : a1);
      n2 = (r < 0) ? 0 : ((k + 1 < a2) ? k + 1 : a2);
      if (step1 !== es1) bs1++;
      if (step2 !== es2) bs2++;
      if (int'(pos1) != m1 + ((d1 < 0) ? -n1 : n1) ||
          int'(pos2) != m2 + ((d2 < 0) ? -n2 : n2)) bp++;
      if (done !== (t == td)) bd++;
      if (done === 1'b1 && first_done < 0) first_done = t;
      if (busy !== 1'b1 || ready !== 1'b0) bb++;
      if (t >= 2 && (dir1 !== (d1 < 0) || dir2 !== (d2 < 0))) bdir++;
      if (t == v.rst) begin
        reset = 1'b1;
        #2;
        chk_reset_vals({nm, " mid-move reset"});
        reset = 1'b0;
        angles_valid = 1'b0;
        m1 = 0;
        m2 = 0;
        aborted = 1;
        break;
      end
    end
    chk({nm, " step1 bad cycles"}, bs1, 0);
    chk({nm, " step2 bad cycles"}, bs2, 0);
    chk({nm, " pos bad cycles"}, bp, 0);
    chk({nm, " done bad cycles"}, bd, 0);
    chk({nm, " busy/ready bad cycles"}, bb, 0);
    chk({nm, " dir bad cycles"}, bdir, 0);
    if (!aborted) begin
      @(negedge clk);
      chk({nm, " ready after done"}, int'({ready, done}), 2);
      m1 = v.t1;
      m2 = v.t2;
    end
    chk({nm, " done cycle"}, first_done, v.exp_done);
    chk({nm, " final pos1"}, int'(pos1), v.exp_p1);
    chk({nm, " final pos2"}, int'(pos2), v.exp_p2);
  endtask

  task automatic span_move(input int tg, input int exp_done, input int exp_rises,
                           input int exp_dir, input string nm);
    int t = 0;
    int c1 = sp_r1;
    int c2 = sp_r2;
    while (sp_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    t = 0;
    sp_th1 = tg[12:0];
    sp_th2 = '0;
    sp_valid = 1'b1;
    do begin
      @(negedge clk);
      sp_valid = 1'b0;
      t++;
    end while (sp_done !== 1'b1 && t < 20000);
    chk({nm, " done cycle"}, t, exp_done);
    chk({nm, " dir1"}, int'(sp_dir1), exp_dir);
    @(negedge clk);
    chk({nm, " step1 pulses"}, sp_r1 - c1, exp_rises);
    chk({nm, " step2 pulses"}, sp_r2 - c2, 0);
    chk({nm, " pos1"}, int'(sp_pos1), tg);
    chk({nm, " ready"}, int'(sp_ready), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    vec_t rv;
    tbl[0] = '{t1: 5,  t2: -3, hmode: 0, inj: 0,  rst: 0,  exp_done: 54, exp_p1: 5,  exp_p2: -3};
    tbl[1] = '{t1: 5,  t2: -3, hmode: 0, inj: 0,  rst: 0,  exp_done: 4,  exp_p1: 5,  exp_p2: -3};
    tbl[2] = '{t1: -2, t2: 4,  hmode: 0, inj: 20, rst: 0,  exp_done: 74, exp_p1: -2, exp_p2: 4};
    tbl[3] = '{t1: 10, t2: 10, hmode: 0, inj: 0,  rst: 25, exp_done: -1, exp_p1: 0,  exp_p2: 0};
    tbl[4] = '{t1: 5,  t2: -3, hmode: 1, inj: 0,  rst: 0,  exp_done: 54, exp_p1: 5,  exp_p2: -3};
    tbl[5] = '{t1: 1,  t2: 1,  hmode: 1, inj: 0,  rst: 0,  exp_done: 14, exp_p1: 1,  exp_p2: 1};
    tbl[6] = '{t1: 3,  t2: -1, hmode: 2, inj: 0,  rst: 0,  exp_done: 24, exp_p1: 3,  exp_p2: -1};

    @(negedge clk);
    @(negedge clk);
    chk_reset_vals("reset held");
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("after reset release");

    for (int i = 0; i < 7; i++) move(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 6; i++) begin
      int d1, d2, a1, a2, mm;
      rv.t1 = int'($urandom_range(40)) - 20;
      rv.t2 = int'($urandom_range(40)) - 20;
      rv.hmode = 0;
      rv.inj = (i % 2 == 1) ? 6 : 0;
      rv.rst = 0;
      d1 = rv.t1 - m1;
      d2 = rv.t2 - m2;
      a1 = (d1 < 0) ? -d1 : d1;
      a2 = (d2 < 0) ? -d2 : d2;
      mm = (a1 > a2) ? a1 : a2;
      rv.exp_done = S + 2 + mm * SD;
      rv.exp_p1 = rv.t1;
      rv.exp_p2 = rv.t2;
      move(rv, $sformatf("rand%0d", i));
    end

    span_move(4095, S + 2 + 4095 * 2, 4095, 0, "span up");
    span_move(-4096, S + 2 + 8191 * 2, 8191, 1, "span down");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
